mem_interface_arbiter: RTL and testbench

Memory interface unit shared by the core's L1 instruction cache and L1 data cache. It accepts cache-line miss requests from both caches, arbitrates them with I-cache priority, and runs each granted request as a sequence of word handshakes on the single memory port. It sits between the caches, which are fed by the fetch/decode and operand-fetch stages, and the memory port; a miss stalls the pipeline until this block signals completion.

---
 rtl/mem_interface_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_interface_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface_arbiter.sv
// Line-fill / write-back arbiter between the L1 I- and D-caches and one memory port (I priority, D wins once after waiting).
// Grant one cycle after a req is seen in IDLE; each word waits on memAck, read words return one cycle after their ack.
module mem_interface_arbiter #(
   parameter int WORD_LENGTH = 32,
   parameter int ADR_WIDTH   = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iReq,
   input  logic [ADR_WIDTH-1:0]   iAdr,
   output logic                   iRvalid,
   output logic [WORD_LENGTH-1:0] iRdata,
   output logic                   iDone,
   input  logic                   dReq,
   input  logic                   dWe,
   input  logic [ADR_WIDTH-1:0]   dAdr,
   input  logic [WORD_LENGTH-1:0] dWdata,
   output logic                   dRvalid,
   output logic [WORD_LENGTH-1:0] dRdata,
   output logic                   dDone,
   output logic [IDX_W-1:0]       xferIdx,
   output logic                   memReq,
   output logic                   memWe,
   output logic [ADR_WIDTH-1:0]   memAdr,
   output logic [WORD_LENGTH-1:0] memWdata,
   input  logic                   memAck,
   input  logic [WORD_LENGTH-1:0] memRdata
);

   localparam int BYTES = WORD_LENGTH / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam logic [ADR_WIDTH-1:0] OFF_MASK = ADR_WIDTH'(BLOCK_WORDS * BYTES - 1);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [IDX_W-1:0]       r_cnt;
   logic [ADR_WIDTH-1:0]   r_base;
   logic                   r_dpend;
   logic                   r_owner_d;
   logic                   r_irv;
   logic                   r_drv;
   logic [WORD_LENGTH-1:0] r_irdata;
   logic [WORD_LENGTH-1:0] r_drdata;
   logic [IDX_W-1:0]       r_xidx;

   logic                   w_xfer;
   logic                   w_last;
   logic                   w_grant_i;
   logic                   w_grant_d;
   logic [ADR_WIDTH-1:0]   w_line;

   assign w_xfer = (r_state == I_RD) || (r_state == D_RD) || (r_state == D_WR);
   assign w_last = (r_cnt == IDX_W'(BLOCK_WORDS - 1));
   assign w_line = (w_grant_d ? dAdr : iAdr) & ~OFF_MASK;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // A D request that waited through an I line overrides the usual I priority once.
   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            if (dReq && (r_dpend || !iReq)) begin
               w_grant_d = 1'b1;
               w_next    = dWe ? D_WR : D_RD;
            end else if (iReq) begin
               w_grant_i = 1'b1;
               w_next    = I_RD;
            end
         end
         I_RD, D_RD, D_WR: if (memAck && w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_base    <= '0;
         r_dpend   <= 1'b0;
         r_owner_d <= 1'b0;
         r_irv     <= 1'b0;
         r_drv     <= 1'b0;
         r_irdata  <= '0;
         r_drdata  <= '0;
         r_xidx    <= '0;
      end else begin
         r_irv <= 1'b0;
         r_drv <= 1'b0;
         if (w_grant_i || w_grant_d) begin
            r_base    <= w_line;
            r_cnt     <= '0;
            r_owner_d <= w_grant_d;
         end else if (w_xfer && memAck && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_grant_d)                    r_dpend <= 1'b0;
         else if (r_state == I_RD && dReq) r_dpend <= 1'b1;
         if (memAck && r_state == I_RD) begin
            r_irv    <= 1'b1;
            r_irdata <= memRdata;
            r_xidx   <= r_cnt;
         end
         if (memAck && r_state == D_RD) begin
            r_drv    <= 1'b1;
            r_drdata <= memRdata;
            r_xidx   <= r_cnt;
         end
      end
   end

   // Outputs decode the state directly so an asynchronous reset drops memReq at once.
   assign memReq   = w_xfer;
   assign memWe    = (r_state == D_WR);
   assign memAdr   = r_base + (ADR_WIDTH'(r_cnt) << BSH);
   assign memWdata = (r_state == D_WR) ? dWdata : '0;
   assign xferIdx  = (r_state == D_WR) ? r_cnt : r_xidx;
   assign iRvalid  = r_irv;
   assign iRdata   = r_irdata;
   assign dRvalid  = r_drv;
   assign dRdata   = r_drdata;
   assign iDone    = (r_state == DONE) && !r_owner_d;
   assign dDone    = (r_state == DONE) && r_owner_d;

endmodule

// File: tb/tb_mem_interface_arbiter.sv
// Directed bench for mem_interface_arbiter: transaction-level model checked every cycle plus literal line checks.
module tb_mem_interface_arbiter;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iReq, dReq, dWe, memAck;
   logic [31:0] iAdr, dAdr, dWdata, memRdata;
   logic        iRvalid, iDone, dRvalid, dDone, memReq, memWe;
   logic [31:0] iRdata, dRdata, memAdr, memWdata;
   logic [1:0]  xferIdx;

   mem_interface_arbiter dut (
      .clk(clk), .rst(rst),
      .iReq(iReq), .iAdr(iAdr), .iRvalid(iRvalid), .iRdata(iRdata), .iDone(iDone),
      .dReq(dReq), .dWe(dWe), .dAdr(dAdr), .dWdata(dWdata),
      .dRvalid(dRvalid), .dRdata(dRdata), .dDone(dDone), .xferIdx(xferIdx),
      .memReq(memReq), .memWe(memWe), .memAdr(memAdr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata)
   );

   always #5 clk = ~clk;

   // The D-cache presents the word selected by xferIdx.
   assign dWdata = 32'hD0 + {30'd0, xferIdx};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: who owns the port, how many words are done, pending D.
   bit          m_busy = 0, m_fin = 0, m_who = 0, m_we = 0, m_dpend = 0, m_rv_i = 0, m_rv_d = 0;
   logic [31:0] m_base = 0, m_rdata = 0;
   int          m_k = 0, m_ridx = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_busy = 0; m_fin = 0; m_who = 0; m_we = 0; m_dpend = 0;
            m_rv_i = 0; m_rv_d = 0; m_base = 0; m_k = 0; m_ridx = 0;
         end else begin
            m_rv_i = 0;
            m_rv_d = 0;
            if (m_fin) begin
               m_busy = 0;
               m_fin  = 0;
            end else if (m_busy) begin
               if (!m_who && dReq) m_dpend = 1;
               if (memAck) begin
                  if (!m_we) begin
                     if (m_who) m_rv_d = 1; else m_rv_i = 1;
                     m_rdata = memRdata;
                     m_ridx  = m_k;
                  end
                  if (m_k == BW - 1) m_fin = 1; else m_k++;
               end
            end else if (dReq && (m_dpend || !iReq)) begin
               m_busy = 1; m_who = 1; m_we = dWe; m_k = 0; m_dpend = 0;
               m_base = dAdr & ~32'(BW * 4 - 1);
            end else if (iReq) begin
               m_busy = 1; m_who = 0; m_we = 0; m_k = 0;
               m_base = iAdr & ~32'(BW * 4 - 1);
            end
         end
      end
   end

   // Observation logs for literal per-line checks.
   logic [31:0] ack_adr_q[$], ack_wd_q[$], rv_dat_q[$];
   bit          ack_we_q[$], rv_who_q[$];
   int          rv_idx_q[$];
   int          i_done_cnt = 0, d_done_cnt = 0;

   initial begin
      bit exp_req;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("reset_outputs", {memReq, memWe, memAdr, memWdata, iRvalid, iRdata, iDone,
                                  dRvalid, dRdata, dDone, xferIdx}, 0);
         end else begin
            exp_req = m_busy && !m_fin;
            chk("memReq", memReq, exp_req);
            chk("memWe", memWe, exp_req && m_we);
            chk("memWdata", memWdata, (exp_req && m_we) ? 32'hD0 + 32'(m_k) : 32'h0);
            if (exp_req) chk("memAdr", memAdr, m_base + 32'(4 * m_k));
            chk("iDone", iDone, m_fin && !m_who);
            chk("dDone", dDone, m_fin && m_who);
            chk("iRvalid", iRvalid, m_rv_i);
            chk("dRvalid", dRvalid, m_rv_d);
            if (m_rv_i) chk("iRdata", iRdata, m_rdata);
            if (m_rv_d) chk("dRdata", dRdata, m_rdata);
            if (m_rv_i || m_rv_d)        chk("xferIdx_rd", xferIdx, m_ridx);
            else if (exp_req && m_we)    chk("xferIdx_wr", xferIdx, m_k);
            if (memReq && memAck) begin
               ack_adr_q.push_back(memAdr);
               ack_wd_q.push_back(memWdata);
               ack_we_q.push_back(memWe);
            end
            if (iRvalid) begin rv_who_q.push_back(0); rv_idx_q.push_back(int'(xferIdx)); rv_dat_q.push_back(iRdata); end
            if (dRvalid) begin rv_who_q.push_back(1); rv_idx_q.push_back(int'(xferIdx)); rv_dat_q.push_back(dRdata); end
            if (iDone) i_done_cnt++;
            if (dDone) d_done_cnt++;
         end
      end
   end

   // Requesters and memory responder, driven 1 time unit after each rising edge.
   int          i_left = 0, d_left = 0, gap_mode = 0, wait_n = 0;
   bit          inj = 0;
   logic [31:0] rd_pat = 32'h0;

   initial begin
      iReq = 0; dReq = 0; memAck = 0; memRdata = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            iReq = 0; dReq = 0; memAck = 0; wait_n = 0;
         end else begin
            if (iDone && i_left > 0) i_left--;
            if (dDone && d_left > 0) d_left--;
            iReq = (i_left > 0);
            dReq = (d_left > 0);
            if (memReq) begin
               if (wait_n == 0) begin
                  memAck = 1;
                  wait_n = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
               end else begin
                  memAck = 0;
                  wait_n--;
               end
            end else begin
               memAck = inj;
               wait_n = 0;
            end
            memRdata = rd_pat + {30'd0, memAdr[3:2]};
         end
      end
   end

   task automatic clear_logs();
      ack_adr_q.delete(); ack_wd_q.delete(); ack_we_q.delete();
      rv_who_q.delete(); rv_idx_q.delete(); rv_dat_q.delete();
   endtask

   task automatic wait_xfers();
      for (int c = 0; c < 400 && (i_left + d_left) > 0; c++) @(posedge clk);
      chk("xfer_timeout", i_left + d_left, 0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   initial begin
      iAdr = 0; dAdr = 0; dWe = 0;
      #1 rst = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      @(posedge clk); #2;

      // I fill at 0x1234, ack every cycle.
      clear_logs(); gap_mode = 0; rd_pat = 32'hA0; iAdr = 32'h0000_1234; i_left = 1;
      wait_xfers();
      chk("t1_nacks", ack_adr_q.size(), 4);
      chk("t1_nrv", rv_dat_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < ack_adr_q.size()) chk("t1_adr", ack_adr_q[k], 32'h1230 + 32'(4 * k));
         if (k < rv_dat_q.size()) begin
            chk("t1_rdata", rv_dat_q[k], 32'hA0 + 32'(k));
            chk("t1_idx", rv_idx_q[k], k);
            chk("t1_who", rv_who_q[k], 0);
         end
      end
      chk("t1_idone", i_done_cnt, 1);

      // D write-back at 0x2000, ack every 2nd cycle.
      clear_logs(); gap_mode = 1; dWe = 1; dAdr = 32'h0000_2000; d_left = 1;
      wait_xfers();
      chk("t2_nacks", ack_adr_q.size(), 4);
      chk("t2_nrv", rv_dat_q.size(), 0);
      for (int k = 0; k < 4; k++) begin
         if (k < ack_adr_q.size()) begin
            chk("t2_adr", ack_adr_q[k], 32'h2000 + 32'(4 * k));
            chk("t2_wdata", ack_wd_q[k], 32'hD0 + 32'(k));
            chk("t2_we", ack_we_q[k], 1);
         end
      end
      chk("t2_ddone", d_done_cnt, 1);

      // Simultaneous I and D, I asks again right away: I, D (pending), I.
      clear_logs(); gap_mode = 0; rd_pat = 32'h30; dWe = 0;
      iAdr = 32'h0000_3000; dAdr = 32'h0000_4000; i_left = 2; d_left = 1;
      wait_xfers();
      chk("t3_nrv", rv_dat_q.size(), 12);
      chk("t3_nacks", ack_adr_q.size(), 12);
      for (int n = 0; n < 12; n++) begin
         if (n < rv_dat_q.size()) begin
            chk("t3_who", rv_who_q[n], (n / 4 == 1) ? 1 : 0);
            chk("t3_idx", rv_idx_q[n], n % 4);
         end
         if (n < ack_adr_q.size())
            chk("t3_adr", ack_adr_q[n], ((n / 4 == 1) ? 32'h4000 : 32'h3000) + 32'(4 * (n % 4)));
      end
      chk("t3_idone", i_done_cnt, 3);
      chk("t3_ddone", d_done_cnt, 2);

      // D fill with random ack gaps and stray acks while idle.
      clear_logs(); gap_mode = 2; rd_pat = 32'h50; inj = 1;
      repeat (3) @(posedge clk);
      #2 dAdr = 32'h0000_5008; d_left = 1;
      wait_xfers();
      repeat (5) @(posedge clk);
      #2 inj = 0;
      chk("t4_nrv", rv_dat_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < rv_dat_q.size()) begin
            chk("t4_who", rv_who_q[k], 1);
            chk("t4_idx", rv_idx_q[k], k);
            chk("t4_rdata", rv_dat_q[k], 32'h50 + 32'(k));
         end
      end
      chk("t4_ddone", d_done_cnt, 3);

      // Reset right after the 2nd ack of an I fill, then a clean refill.
      clear_logs(); gap_mode = 0; rd_pat = 32'h60; iAdr = 32'h0000_6014; i_left = 1;
      for (int c = 0; c < 100 && ack_adr_q.size() < 2; c++) @(negedge clk);
      chk("t5_two_acks", ack_adr_q.size(), 2);
      @(posedge clk);
      #3 rst = 0;
      #1 chk("t5_async_rst", {memReq, memWe, memAdr, memWdata, iRvalid, iRdata, iDone,
                              dRvalid, dRdata, dDone, xferIdx}, 0);
      i_left = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      chk("t5_no_idone", i_done_cnt, 3);
      @(posedge clk); #2;
      clear_logs(); i_left = 1;
      wait_xfers();
      chk("t5_nacks", ack_adr_q.size(), 4);
      if (ack_adr_q.size() > 0) chk("t5_first_adr", ack_adr_q[0], 32'h6010);
      chk("t5_nrv", rv_dat_q.size(), 4);
      if (rv_dat_q.size() > 0) begin
         chk("t5_first_idx", rv_idx_q[0], 0);
         chk("t5_first_data", rv_dat_q[0], 32'h60);
      end
      chk("t5_idone", i_done_cnt, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule
